channel_avg_engine: RTL and testbench

CHANNEL_AVG_ENGINE -- requirements
Module: channel_avg_engine

---
 rtl/channel_avg_engine_pkg.sv | 22 ++
 rtl/channel_avg_engine_adder_tree_p.sv | 47 ++++
 rtl/channel_avg_engine.sv | 138 +++++++++++++
 tb/tb_channel_avg_engine.sv | 159 +++++++++++++++
 4 files changed

// File: rtl/channel_avg_engine_pkg.sv
// rtl/channel_avg_engine_pkg.sv - shared constants and helpers for the channel averaging engine
//
// Purpose : clog2 helper for parameter derivation and the control FSM
//           state encoding shared by the engine and its sub-modules.
// Ports   : none (package).
package channel_avg_engine_pkg;

   // Smallest r with 2**r >= value; used only on elaboration-time constants.
   function automatic int clog2(input int value);
      int r;
      r = 0;
      for (int i = 0; i < 32; i++) begin
         if ((1 << r) < value) r = r + 1;
      end
      return r;
   endfunction

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_RUN   = 2'd1;
   localparam logic [1:0] ST_DRAIN = 2'd2;

endpackage

// File: rtl/channel_avg_engine_adder_tree_p.sv
// rtl/channel_avg_engine_adder_tree_p.sv - pipelined CH-input adder tree, one register per level
//
// Purpose : sums CH unsigned DW-bit operands; result appears P=clog2(CH)
//           rising edges after the operands are presented.
// Ports   : clk    - clock, rising edge
//           rst    - asynchronous active-low reset, clears every node
//           i_data - CH operands packed, operand n at [n*DW +: DW]
//           o_sum  - registered total, DW+CW bits
module adder_tree_p
   import channel_avg_engine_pkg::*;
#(
   parameter int CH = 8,
   parameter int DW = 8,
   localparam int CW = clog2(CH),
   localparam int OW = DW + CW
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [CH*DW-1:0] i_data,
   output logic [OW-1:0]    o_sum
);

   // Heap layout: node i has children 2i and 2i+1. Indices 1..CH-1 are
   // registered sums, CH..2*CH-1 are the unregistered leaves. Since CH is a
   // power of two every leaf sits at the same depth, so all paths have
   // exactly CW registers. Full output width at every node keeps the
   // arithmetic uniform; the top bits of shallow nodes simply stay zero.
   logic [OW-1:0] r_node [1:CH-1];
   logic [OW-1:0] w_all  [2:2*CH-1];

   always_comb begin
      for (int i = 2; i < 2 * CH; i++) w_all[i] = '0;
      for (int i = 2; i < CH; i++) w_all[i] = r_node[i];
      for (int i = 0; i < CH; i++) w_all[CH + i] = OW'(i_data[i*DW +: DW]);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 1; i < CH; i++) r_node[i] <= '0;
      end else begin
         for (int i = 1; i < CH; i++) r_node[i] <= w_all[2*i] + w_all[2*i + 1];
      end
   end

   assign o_sum = r_node[1];

endmodule

// File: rtl/channel_avg_engine.sv
// rtl/channel_avg_engine.sv - multi-channel sample store with pipelined sum and rounded mean
//
// Purpose : holds CH x DEPTH samples; a start request sweeps every sample
//           index through an adder tree into an accumulator and publishes
//           the exact sum and round-half-up mean.
// Ports   : clk     - clock, rising edge
//           rst     - asynchronous active-low reset
//           wr_en   - sample write strobe (ignored while busy)
//           wr_ch   - channel of the write
//           wr_addr - sample index of the write
//           wr_data - unsigned sample value
//           start   - request one averaging pass (ignored while busy)
//           busy    - pass in progress, through the done cycle
//           done    - one-cycle pulse when sum/avg update
//           sum     - exact total from the last completed pass
//           avg     - rounded mean from the last completed pass
module channel_avg_engine
   import channel_avg_engine_pkg::*;
#(
   parameter int CH    = 8,
   parameter int DW    = 8,
   parameter int DEPTH = 32,
   localparam int CW   = clog2(CH),
   localparam int AW   = clog2(DEPTH),
   localparam int K    = CW + AW,
   localparam int SW   = DW + K,
   localparam int P    = CW
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          wr_en,
   input  logic [CW-1:0] wr_ch,
   input  logic [AW-1:0] wr_addr,
   input  logic [DW-1:0] wr_data,
   input  logic          start,
   output logic          busy,
   output logic          done,
   output logic [SW-1:0] sum,
   output logic [DW-1:0] avg
);

   localparam logic [SW:0] HALF = (SW + 1)'(1) << (K - 1);

   logic [DW-1:0]    r_mem [CH][DEPTH];
   logic [1:0]       r_state;
   logic [AW-1:0]    r_idx;
   logic [P-1:0]     r_vld_pipe;
   logic [P-1:0]     r_last_pipe;
   logic [SW-1:0]    r_acc;
   logic             r_acc_last;
   logic             r_done;
   logic [SW-1:0]    r_sum;
   logic [DW-1:0]    r_avg;

   logic             w_run;
   logic             w_last_idx;
   logic             w_tree_vld;
   logic             w_tree_last;
   logic [CH*DW-1:0] w_rd;
   logic [DW+CW-1:0] w_tree_sum;

   assign w_run       = (r_state == ST_RUN);
   assign w_last_idx  = w_run && (r_idx == AW'(DEPTH - 1));
   assign w_tree_vld  = r_vld_pipe[P-1];
   assign w_tree_last = r_last_pipe[P-1];

   // Sample store has no reset; contents are whatever was last written.
   always_ff @(posedge clk) begin
      if (wr_en && (r_state == ST_IDLE)) r_mem[wr_ch][wr_addr] <= wr_data;
   end

   always_comb begin
      w_rd = '0;
      for (int c = 0; c < CH; c++) w_rd[c*DW +: DW] = r_mem[c][r_idx];
   end

   adder_tree_p #(
      .CH (CH),
      .DW (DW)
   ) u_tree (
      .clk    (clk),
      .rst    (rst),
      .i_data (w_rd),
      .o_sum  (w_tree_sum)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state     <= ST_IDLE;
         r_idx       <= '0;
         r_vld_pipe  <= '0;
         r_last_pipe <= '0;
         r_acc       <= '0;
         r_acc_last  <= 1'b0;
         r_done      <= 1'b0;
         r_sum       <= '0;
         r_avg       <= '0;
      end else begin
         r_done      <= 1'b0;
         // Valid/last tags ride alongside the tree so the accumulator knows
         // which tree outputs belong to this pass and which one is final.
         r_vld_pipe  <= (r_vld_pipe << 1) | P'(w_run);
         r_last_pipe <= (r_last_pipe << 1) | P'(w_last_idx);
         r_acc_last  <= w_tree_vld & w_tree_last;
         if (w_tree_vld) r_acc <= r_acc + SW'(w_tree_sum);

         case (r_state)
            ST_IDLE: begin
               if (start) begin
                  r_state <= ST_RUN;
                  r_idx   <= '0;
                  r_acc   <= '0;
               end
            end
            ST_RUN: begin
               r_idx <= r_idx + 1'b1;
               if (r_idx == AW'(DEPTH - 1)) r_state <= ST_DRAIN;
            end
            ST_DRAIN: begin
               // DRAIN also covers the done cycle so busy stays high through it.
               if (r_acc_last) begin
                  r_done <= 1'b1;
                  r_sum  <= r_acc;
                  r_avg  <= DW'(({1'b0, r_acc} + HALF) >> K);
               end
               if (r_done) r_state <= ST_IDLE;
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign busy = (r_state != ST_IDLE);
   assign done = r_done;
   assign sum  = r_sum;
   assign avg  = r_avg;

endmodule

// File: tb/tb_channel_avg_engine.sv
// tb/tb_channel_avg_engine.sv - directed self-checking bench for channel_avg_engine
module tb_channel_avg_engine;

   localparam int CH    = 8;
   localparam int DW    = 8;
   localparam int DEPTH = 32;
   localparam int LAT   = 36;

   logic        clk;
   logic        rst;
   logic        wr_en;
   logic [2:0]  wr_ch;
   logic [4:0]  wr_addr;
   logic [7:0]  wr_data;
   logic        start;
   logic        busy;
   logic        done;
   logic [15:0] sum;
   logic [7:0]  avg;

   int n_vec;
   int n_err;

   channel_avg_engine #(
      .CH    (CH),
      .DW    (DW),
      .DEPTH (DEPTH)
   ) dut (
      .clk     (clk),
      .rst     (rst),
      .wr_en   (wr_en),
      .wr_ch   (wr_ch),
      .wr_addr (wr_addr),
      .wr_data (wr_data),
      .start   (start),
      .busy    (busy),
      .done    (done),
      .sum     (sum),
      .avg     (avg)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic wr(input int c, input int a, input int d);
      wr_en   = 1'b1;
      wr_ch   = 3'(c);
      wr_addr = 5'(a);
      wr_data = 8'(d);
      @(negedge clk);
      wr_en   = 1'b0;
   endtask

   // mode 0: constant val, mode 1: entry [c][a] = a
   task automatic fill(input int mode, input int val);
      for (int c = 0; c < CH; c++)
         for (int a = 0; a < DEPTH; a++)
            wr(c, a, (mode == 1) ? a : val);
   endtask

   // Starts a pass at the current negedge and returns at the negedge after
   // the done cycle. disturb injects start + write during RUN.
   task automatic run_pass(input string tag, input int exp_sum, input int exp_avg,
                           input bit disturb);
      int lat;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      chk({tag, "_busy_start"}, 32'(busy), 32'd1);
      lat = 0;
      while (done !== 1'b1 && lat < 100) begin
         if (disturb && lat == 5) begin
            start   = 1'b1;
            wr_en   = 1'b1;
            wr_ch   = 3'd0;
            wr_addr = 5'd0;
            wr_data = 8'hFF;
         end
         @(negedge clk);
         start = 1'b0;
         wr_en = 1'b0;
         lat++;
      end
      chk({tag, "_latency"}, 32'(lat), 32'(LAT));
      chk({tag, "_sum"}, 32'(sum), 32'(exp_sum));
      chk({tag, "_avg"}, 32'(avg), 32'(exp_avg));
      chk({tag, "_busy_done"}, 32'(busy), 32'd1);
      @(negedge clk);
      chk({tag, "_done_width"}, 32'(done), 32'd0);
      chk({tag, "_busy_end"}, 32'(busy), 32'd0);
   endtask

   initial begin
      int dcount;
      n_vec   = 0;
      n_err   = 0;
      rst     = 1'b0;
      wr_en   = 1'b0;
      wr_ch   = '0;
      wr_addr = '0;
      wr_data = '0;
      start   = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_sum",  32'(sum),  32'd0);
      chk("rst_avg",  32'(avg),  32'd0);
      rst = 1'b1;
      @(negedge clk);

      fill(0, 255);
      run_pass("all_ff", 65280, 255, 1'b0);

      fill(1, 0);
      run_pass("ramp", 3968, 16, 1'b0);
      run_pass("disturb", 3968, 16, 1'b1);
      run_pass("b2b", 3968, 16, 1'b0);

      // Reset at cycle 10 of RUN aborts the pass.
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (9) @(negedge clk);
      #2 rst = 1'b0;
      #1;
      chk("midrst_busy", 32'(busy), 32'd0);
      chk("midrst_sum",  32'(sum),  32'd0);
      chk("midrst_avg",  32'(avg),  32'd0);
      chk("midrst_done", 32'(done), 32'd0);
      @(negedge clk);
      rst = 1'b1;
      dcount = 0;
      for (int i = 0; i < 60; i++) begin
         @(negedge clk);
         if (done === 1'b1) dcount++;
      end
      chk("midrst_no_done", 32'(dcount), 32'd0);
      chk("midrst_idle", 32'(busy), 32'd0);
      run_pass("after_rst", 3968, 16, 1'b0);

      fill(0, 0);
      wr(3, 17, 128);
      run_pass("single128", 128, 1, 1'b0);
      wr(3, 17, 127);
      run_pass("single127", 127, 0, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
